// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: bus widths, the I/O
// window base, access size codes and the controller FSM states.
package mem_ctrl_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam logic [31:0] IO_ADDR_BASE_DEF = 32'h0003_0000;

  // Access size codes are bytes-1
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } slb_req_t;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetcher, SLB and byte-wide RAM/IO bus signals of the memory controller.
// The controller takes the slave view; fetcher/SLB/RAM side takes the master view.
interface mem_ctrl_if;

  logic        in_fetcher_get_instr;
  logic [31:0] in_fetcher_pc;
  logic        out_fetcher_get_instr;
  logic [31:0] out_fetcher_instr;

  logic        in_slb_req;
  logic        in_slb_wr;
  logic [1:0]  in_slb_size;
  logic [31:0] in_slb_addr;
  logic [31:0] in_slb_data;
  logic        out_slb_done;
  logic [31:0] out_slb_data;

  logic        in_misbranch;
  logic        in_io_buffer_full;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  in_fetcher_get_instr, in_fetcher_pc,
    output out_fetcher_get_instr, out_fetcher_instr,
    input  in_slb_req, in_slb_wr, in_slb_size, in_slb_addr, in_slb_data,
    output out_slb_done, out_slb_data,
    input  in_misbranch, in_io_buffer_full, mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output in_fetcher_get_instr, in_fetcher_pc,
    input  out_fetcher_get_instr, out_fetcher_instr,
    output in_slb_req, in_slb_wr, in_slb_size, in_slb_addr, in_slb_data,
    input  out_slb_done, out_slb_data,
    output in_misbranch, in_io_buffer_full, mem_din,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: latches fetch and load/store requests, arbitrates (SLB first)
// and serialises each access into byte transfers on the 8-bit RAM/IO bus.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_ADDR_BASE = IO_ADDR_BASE_DEF,
  parameter int unsigned BYTE_LAT     = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave bus
);

  localparam logic [3:0] LAT = 4'(BYTE_LAT);

  // Pending request latches
  logic        r_f_pend;
  logic [31:0] r_f_pc;
  logic        r_s_pend;
  slb_req_t    r_s_req;

  // Access in progress
  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sel_slb;
  logic [31:0] r_base;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_buf;

  // Registered outputs
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_f_done;
  logic        r_s_done;
  logic [31:0] r_instr;
  logic [31:0] r_sdata;

  logic        w_f_live;
  logic        w_s_live;
  logic        w_start;
  logic        w_f_clear;
  logic        w_f_accept;
  logic        w_s_clear;
  logic        w_s_accept;
  logic        w_is_io;
  logic        w_wr_fire;
  logic        w_wr_last;
  logic [1:0]  w_k_inc;
  logic        w_rd_cap;
  logic [1:0]  w_rd_idx;
  logic        w_rd_last;
  logic [31:0] w_buf_nxt;

  // A misbranch kills fetches and loads in the same cycle it is seen
  assign w_f_live = r_f_pend && !bus.in_misbranch;
  assign w_s_live = r_s_pend && !(bus.in_misbranch && !r_s_req.wr);
  assign w_start  = (r_state == ST_IDLE) && (w_f_live || w_s_live);

  assign w_f_clear  = bus.in_misbranch || ((r_state == ST_DONE) && !r_sel_slb);
  assign w_f_accept = bus.in_fetcher_get_instr && !bus.in_misbranch && (!r_f_pend || w_f_clear);
  assign w_s_clear  = (bus.in_misbranch && !r_s_req.wr) || ((r_state == ST_DONE) && r_sel_slb);
  assign w_s_accept = bus.in_slb_req && !(bus.in_misbranch && !bus.in_slb_wr) &&
                      (!r_s_pend || w_s_clear);

  assign w_is_io   = (r_mem_a >= IO_ADDR_BASE);
  assign w_wr_fire = (r_state == ST_WRITE) && !(w_is_io && bus.in_io_buffer_full);
  assign w_wr_last = w_wr_fire && (r_cnt[1:0] == r_size);
  assign w_k_inc   = r_cnt[1:0] + 2'd1;

  // Read data trails the address by LAT cycles, so capture index = r_cnt - LAT
  assign w_rd_cap  = (r_state == ST_READ) && (r_cnt >= LAT);
  assign w_rd_idx  = 2'(r_cnt - LAT);
  assign w_rd_last = w_rd_cap && (w_rd_idx == r_size);

  always_comb begin
    w_buf_nxt = r_buf;
    if (w_rd_cap) begin
      w_buf_nxt[{w_rd_idx, 3'b000} +: 8] = bus.mem_din;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_s_live) begin
          w_state_nxt = r_s_req.wr ? ST_WRITE : ST_READ;
        end else if (w_f_live) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (bus.in_misbranch) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rd_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (w_wr_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // A pulse landing on the DONE cycle of its own requester re-arms the latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_pend <= 1'b0;
      r_f_pc   <= '0;
      r_s_pend <= 1'b0;
      r_s_req  <= '0;
    end else if (rdy) begin
      if (w_f_accept) begin
        r_f_pend <= 1'b1;
        r_f_pc   <= bus.in_fetcher_pc;
      end else if (w_f_clear) begin
        r_f_pend <= 1'b0;
      end
      if (w_s_accept) begin
        r_s_pend <= 1'b1;
        r_s_req  <= '{wr:   bus.in_slb_wr,
                      size: bus.in_slb_size,
                      addr: bus.in_slb_addr,
                      data: bus.in_slb_data};
      end else if (w_s_clear) begin
        r_s_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_slb  <= 1'b0;
      r_base     <= '0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_f_done   <= 1'b0;
      r_s_done   <= 1'b0;
      r_instr    <= '0;
      r_sdata    <= '0;
    end else if (rdy) begin
      r_f_done <= 1'b0;
      r_s_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_sel_slb  <= w_s_live;
            r_base     <= w_s_live ? r_s_req.addr : r_f_pc;
            r_size     <= w_s_live ? r_s_req.size : SIZE_WORD;
            r_wdata    <= r_s_req.data;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_mem_a    <= w_s_live ? r_s_req.addr : r_f_pc;
            r_mem_dout <= w_s_live ? r_s_req.data[7:0] : '0;
          end
        end
        ST_READ: begin
          if (!bus.in_misbranch) begin
            r_cnt <= r_cnt + 4'd1;
            r_buf <= w_buf_nxt;
            if (r_cnt < {2'b00, r_size}) begin
              r_mem_a <= r_base + 32'(r_cnt + 4'd1);
            end
            if (w_rd_last) begin
              if (r_sel_slb) begin
                r_s_done <= 1'b1;
                r_sdata  <= w_buf_nxt;
              end else begin
                r_f_done <= 1'b1;
                r_instr  <= w_buf_nxt;
              end
            end
          end
        end
        ST_WRITE: begin
          if (w_wr_last) begin
            r_s_done <= 1'b1;
            r_sdata  <= '0;
          end else if (w_wr_fire) begin
            r_cnt      <= r_cnt + 4'd1;
            r_mem_a    <= r_base + {30'b0, w_k_inc};
            r_mem_dout <= byte_sel(r_wdata, w_k_inc);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_fetcher_get_instr = r_f_done;
  assign bus.out_fetcher_instr     = r_instr;
  assign bus.out_slb_done          = r_s_done;
  assign bus.out_slb_data          = r_sdata;
  assign bus.mem_a                 = r_mem_a;
  assign bus.mem_dout              = r_mem_dout;
  assign bus.mem_wr                = w_wr_fire;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte-wide RAM model with one-cycle read latency
// and an I/O write sink, driven by a linear sequence of request scenarios.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl #(
    .IO_ADDR_BASE(32'h0003_0000),
    .BYTE_LAT    (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  logic [7:0]  ram [0:65535];
  int unsigned io_n;
  logic [7:0]  io_last;

  always @(posedge clk) begin
    if (rst) begin
      ram[16'h1000] <= 8'h13; ram[16'h1001] <= 8'h05; ram[16'h1002] <= 8'hA0; ram[16'h1003] <= 8'h00;
      ram[16'h1004] <= 8'h93; ram[16'h1005] <= 8'h00; ram[16'h1006] <= 8'h10; ram[16'h1007] <= 8'h00;
      ram[16'h2000] <= 8'h78; ram[16'h2001] <= 8'h56; ram[16'h2002] <= 8'h34; ram[16'h2003] <= 8'h12;
      ram[16'h0200] <= 8'h6F; ram[16'h0201] <= 8'h00; ram[16'h0202] <= 8'h00; ram[16'h0203] <= 8'h00;
      io_n    <= 0;
      io_last <= 8'h00;
    end else if (rdy) begin
      bus.mem_din <= ram[bus.mem_a[15:0]];
      if (bus.mem_wr) begin
        if (bus.mem_a >= 32'h0003_0000) begin
          io_n    <= io_n + 1;
          io_last <= bus.mem_dout;
        end else begin
          ram[bus.mem_a[15:0]] <= bus.mem_dout;
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  int          f_n, f_at, s_n, s_at, w_n;
  logic [31:0] f_val, s_val;
  logic [31:0] w_a [4];
  logic [7:0]  w_d [4];
  int          w_at [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks n cycles; cycle numbers are counted from 'start' relative to the request edge
  task automatic watch(input int start, input int n);
    f_n = 0; s_n = 0; w_n = 0; f_at = -1; s_at = -1;
    for (int i = start; i < start + n; i++) begin
      tick();
      if (bus.out_fetcher_get_instr) begin f_n++; f_at = i; f_val = bus.out_fetcher_instr; end
      if (bus.out_slb_done) begin s_n++; s_at = i; s_val = bus.out_slb_data; end
      if (bus.mem_wr) begin
        if (w_n < 4) begin w_a[w_n] = bus.mem_a; w_d[w_n] = bus.mem_dout; w_at[w_n] = i; end
        w_n++;
      end
    end
  endtask

  task automatic fetch_pulse(input logic [31:0] pc);
    bus.in_fetcher_pc        = pc;
    bus.in_fetcher_get_instr = 1'b1;
    tick();
    bus.in_fetcher_get_instr = 1'b0;
  endtask

  task automatic slb_pulse(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] data);
    bus.in_slb_wr   = wr;
    bus.in_slb_size = size;
    bus.in_slb_addr = addr;
    bus.in_slb_data = data;
    bus.in_slb_req  = 1'b1;
    tick();
    bus.in_slb_req  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int unsigned io_base;

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.in_fetcher_get_instr = 1'b0;
    bus.in_fetcher_pc        = '0;
    bus.in_slb_req           = 1'b0;
    bus.in_slb_wr            = 1'b0;
    bus.in_slb_size          = '0;
    bus.in_slb_addr          = '0;
    bus.in_slb_data          = '0;
    bus.in_misbranch         = 1'b0;
    bus.in_io_buffer_full    = 1'b0;

    // Reset state
    idle(3);
    chk("rst_fstrobe", {31'b0, bus.out_fetcher_get_instr}, 32'd0);
    chk("rst_instr",   bus.out_fetcher_instr, 32'd0);
    chk("rst_sdone",   {31'b0, bus.out_slb_done}, 32'd0);
    chk("rst_sdata",   bus.out_slb_data, 32'd0);
    chk("rst_mem_a",   bus.mem_a, 32'd0);
    chk("rst_dout",    {24'b0, bus.mem_dout}, 32'd0);
    chk("rst_mem_wr",  {31'b0, bus.mem_wr}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Uncontended fetch: address pc..pc+3 in T+1..T+4, strobe in T+6
    fetch_pulse(32'h1000);
    tick(); chk("f1_addr_t1", bus.mem_a, 32'h1000);
    tick(); chk("f1_addr_t2", bus.mem_a, 32'h1001);
    tick();
    tick(); chk("f1_addr_t4", bus.mem_a, 32'h1003);
    watch(5, 4);
    chk("f1_strobe_n",  32'(f_n), 32'd1);
    chk("f1_strobe_at", 32'(f_at), 32'd6);
    chk("f1_instr",     f_val, 32'h00A0_0513);
    chk("f1_no_write",  32'(w_n), 32'd0);
    idle(2);

    // Fetch and word load together: load first (T+6), fetch follows (T+13)
    bus.in_fetcher_pc        = 32'h1004;
    bus.in_fetcher_get_instr = 1'b1;
    bus.in_slb_wr   = 1'b0;
    bus.in_slb_size = 2'd3;
    bus.in_slb_addr = 32'h2000;
    bus.in_slb_data = 32'h0;
    bus.in_slb_req  = 1'b1;
    tick();
    bus.in_fetcher_get_instr = 1'b0;
    bus.in_slb_req           = 1'b0;
    watch(1, 20);
    chk("arb_load_n",   32'(s_n), 32'd1);
    chk("arb_load_at",  32'(s_at), 32'd6);
    chk("arb_load_val", s_val, 32'h1234_5678);
    chk("arb_fetch_n",  32'(f_n), 32'd1);
    chk("arb_fetch_at", 32'(f_at), 32'd13);
    chk("arb_fetch_val", f_val, 32'h0010_0093);
    idle(2);

    // Byte load zero-extends; shortest read completes in T+3
    slb_pulse(1'b0, 2'd0, 32'h2003, 32'h0);
    watch(1, 6);
    chk("lb_n",   32'(s_n), 32'd1);
    chk("lb_at",  32'(s_at), 32'd3);
    chk("lb_val", s_val, 32'h0000_0012);
    idle(2);

    // Store half 0xBEEF at 0x104: two write cycles, done the cycle after
    slb_pulse(1'b1, 2'd1, 32'h0104, 32'h0000_BEEF);
    watch(1, 8);
    chk("sh_wr_n",   32'(w_n), 32'd2);
    chk("sh_wr0_at", 32'(w_at[0]), 32'd1);
    chk("sh_wr0_a",  w_a[0], 32'h0104);
    chk("sh_wr0_d",  {24'b0, w_d[0]}, 32'h00EF);
    chk("sh_wr1_at", 32'(w_at[1]), 32'd2);
    chk("sh_wr1_a",  w_a[1], 32'h0105);
    chk("sh_wr1_d",  {24'b0, w_d[1]}, 32'h00BE);
    chk("sh_done_n",  32'(s_n), 32'd1);
    chk("sh_done_at", 32'(s_at), 32'd3);
    chk("sh_data",    s_val, 32'd0);
    idle(2);

    // Misbranch while the fetch is addressing byte 2: no strobe, next fetch clean
    fetch_pulse(32'h1000);
    idle(3);
    chk("mb_addr_k2", bus.mem_a, 32'h1002);
    bus.in_misbranch = 1'b1;
    tick();
    bus.in_misbranch = 1'b0;
    watch(5, 10);
    chk("mb_no_strobe", 32'(f_n), 32'd0);
    fetch_pulse(32'h0200);
    watch(1, 10);
    chk("mb_refetch_n",   32'(f_n), 32'd1);
    chk("mb_refetch_at",  32'(f_at), 32'd6);
    chk("mb_refetch_val", f_val, 32'h0000_006F);
    idle(2);

    // I/O store held off by a full buffer for 5 cycles, then one write
    io_base = io_n;
    bus.in_io_buffer_full = 1'b1;
    slb_pulse(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
    watch(1, 5);
    chk("io_held_wr",   32'(w_n), 32'd0);
    chk("io_held_done", 32'(s_n), 32'd0);
    bus.in_io_buffer_full = 1'b0;
    #1;
    chk("io_wr_now",  {31'b0, bus.mem_wr}, 32'd1);
    chk("io_wr_addr", bus.mem_a, 32'h0003_0000);
    chk("io_wr_data", {24'b0, bus.mem_dout}, 32'h0041);
    watch(6, 8);
    chk("io_done_n",  32'(s_n), 32'd1);
    chk("io_done_at", 32'(s_at), 32'd6);
    chk("io_extra_wr", 32'(w_n), 32'd0);
    chk("io_sink_n",  io_n - io_base, 32'd1);
    chk("io_sink_d",  {24'b0, io_last}, 32'h0041);
    idle(2);

    // rdy low for 3 cycles mid-fetch stretches the access by 3 cycles
    fetch_pulse(32'h1004);
    idle(2);
    rdy = 1'b0;
    idle(3);
    chk("rdy_hold_a", bus.mem_a, 32'h1005);
    chk("rdy_hold_strobe", {31'b0, bus.out_fetcher_get_instr}, 32'd0);
    rdy = 1'b1;
    watch(6, 8);
    chk("rdy_fetch_n",   32'(f_n), 32'd1);
    chk("rdy_fetch_at",  32'(f_at), 32'd9);
    chk("rdy_fetch_val", f_val, 32'h0010_0093);
    idle(2);

    // Reset in the middle of a word store: bus idles, store is not replayed
    slb_pulse(1'b1, 2'd3, 32'h0300, 32'hCAFE_F00D);
    tick();
    chk("rw_wr_active", {31'b0, bus.mem_wr}, 32'd1);
    chk("rw_wr_a0",     bus.mem_a, 32'h0300);
    chk("rw_wr_d0",     {24'b0, bus.mem_dout}, 32'h000D);
    tick();
    rst = 1'b1;
    tick();
    chk("rw_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("rw_sdone",  {31'b0, bus.out_slb_done}, 32'd0);
    chk("rw_fstrb",  {31'b0, bus.out_fetcher_get_instr}, 32'd0);
    chk("rw_mem_a",  bus.mem_a, 32'd0);
    rst = 1'b0;
    watch(0, 10);
    chk("rw_no_replay_wr",   32'(w_n), 32'd0);
    chk("rw_no_replay_done", 32'(s_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
